// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified instruction/data memory port between the CPU control
// path (requester 0) and the program loader/debug port (requester 1).
// The block owns the memory strobes and holds every access for a fixed
// number of wait states. When the access ends it returns read data to the
// winning requester and gives that requester a one-cycle done pulse.
//
// Ports
//   clk, nrst            clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata CPU request; req held until cpu_done
//   cpu_rdata            CPU read data, registered, held until next CPU read
//   cpu_done             one-cycle completion pulse to the CPU
//   cpu_stall            cpu_req & ~cpu_done; the CPU FSM freezes on it
//   ldr_req/we/addr/wdata loader request; req held until ldr_done
//   ldr_rdata            loader read data, registered
//   ldr_done             one-cycle completion pulse to the loader
//   mem_addr/mem_wdata   memory address / write data (hold last grant)
//   mem_rd/mem_wr        memory strobes, only asserted during ACCESS
//   mem_rdata            memory read data, valid while mem_rd is high
//   busy                 high while an access or its response is in flight
//   owner                0 = CPU, 1 = loader; the current or last grant
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int WAIT_CYCLES   = 2,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_done,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_CPU_BURST);

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [3:0]    streak_reg, streak_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
    logic          we_reg, we_next;
    logic          owner_reg, owner_next;
    logic [DW-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DW-1:0] ldr_rdata_reg, ldr_rdata_next;
    logic          loader_wins;

    // State and datapath registers. Every register resets asynchronously,
    // so a reset in the middle of ACCESS drops the strobes immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            streak_reg    <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            owner_reg     <= 1'b0;
            cpu_rdata_reg <= '0;
            ldr_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            streak_reg    <= streak_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            we_reg        <= we_next;
            owner_reg     <= owner_next;
            cpu_rdata_reg <= cpu_rdata_next;
            ldr_rdata_reg <= ldr_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        streak_next    = streak_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        we_next        = we_reg;
        owner_next     = owner_reg;
        cpu_rdata_next = cpu_rdata_reg;
        ldr_rdata_next = ldr_rdata_reg;
        // The CPU has priority. The loader wins when it is the only
        // requester, or when the CPU has used up its streak while the
        // loader waited.
        loader_wins    = ldr_req & (~cpu_req | (streak_reg == BURST_MAX));

        case (state_reg)
            IDLE: begin
                if (cpu_req | ldr_req) begin
                    owner_next = loader_wins;
                    if (loader_wins) begin
                        addr_next   = ldr_addr;
                        wdata_next  = ldr_wdata;
                        we_next     = ldr_we;
                        streak_next = '0;
                    end else begin
                        addr_next   = cpu_addr;
                        wdata_next  = cpu_wdata;
                        we_next     = cpu_we;
                        // The streak counts only CPU grants made while the
                        // loader is waiting.
                        streak_next = ldr_req ? streak_reg + 4'd1 : 4'd0;
                    end
                    cnt_next   = WAIT_LOAD;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    // Last wait state: mem_rdata is still valid because
                    // mem_rd is held through this cycle.
                    if (!we_reg) begin
                        if (owner_reg) ldr_rdata_next = mem_rdata;
                        else           cpu_rdata_next = mem_rdata;
                    end
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded straight from registered state, so they are
    // free of glitches and they clear at once on reset.
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_rd    = (state_reg == ACCESS) & ~we_reg;
    assign mem_wr    = (state_reg == ACCESS) &  we_reg;
    assign busy      = (state_reg == ACCESS) | (state_reg == RESP);
    assign owner     = owner_reg;
    assign cpu_done  = (state_reg == RESP) & ~owner_reg;
    assign ldr_done  = (state_reg == RESP) &  owner_reg;
    assign cpu_stall = cpu_req & ~cpu_done;
    assign cpu_rdata = cpu_rdata_reg;
    assign ldr_rdata = ldr_rdata_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single unified instruction/data memory port between two requesters.
- Requester 0 is the multi-cycle CPU control path (fetch/load/store). Requester 1 is the program loader/debug port.
- Owns all memory strobes and applies a fixed wait-state count.
- Returns read data plus a one-cycle completion pulse. The CPU FSM holds its current state while cpu_stall is high.

Parameters:
- AW, 32, address width
- DW, 32, data width
- WAIT_CYCLES, 2, cycles mem_rd/mem_wr are held per access (legal range 1..15)
- MAX_CPU_BURST, 4, consecutive CPU grants allowed while loader waits before the loader is forced a grant (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request; held until cpu_done
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, registered
- cpu_done  out  1  one-cycle completion pulse to CPU
- cpu_stall  out  1  cpu_req & ~cpu_done
- ldr_req  in  1  loader request; held until ldr_done
- ldr_we  in  1  1=write, 0=read
- ldr_addr  in  AW  loader address
- ldr_wdata  in  DW  loader write data
- ldr_rdata  out  DW  loader read data, registered
- ldr_done  out  1  one-cycle completion pulse to loader
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_rdata  in  DW  memory read data, valid while mem_rd is high
- busy  out  1  high in ACCESS and RESP
- owner  out  1  0=CPU, 1=loader; the current or last grant

Behaviour:

Reset:
- On nrst low, asynchronously: state=IDLE, all outputs 0, streak=0, wait counter=0, latched address/data/we=0.
- Reset during ACCESS abandons the access. Strobes drop immediately and no done pulse is issued.

States:
- IDLE:
  - If any request is high, choose a winner, latch its addr/wdata/we and set owner.
  - Load the wait counter with WAIT_CYCLES-1, then go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched values.
  - mem_rd = ~we_l; mem_wr = we_l.
  - Decrement the counter each cycle.
  - When counter==0: if it is a read, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP:
  - Strobes are 0.
  - Pulse the owner's done signal for exactly one cycle, then go to IDLE.

Latency and handshake:
- A request sampled in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and done in cycle WAIT_CYCLES+1.
- The next grant is possible at cycle WAIT_CYCLES+2.
- Requesters keep req/addr/we/wdata stable until done and drop req on the cycle after done.
- A req still high in the IDLE cycle after done is treated as a new request.
- If a requester drops req mid-access, the access still completes and done still pulses.
- Input changes after the IDLE sampling edge are ignored.

Arbitration:
- Fixed CPU priority, with a starvation guard.
- The streak counter increments on each CPU grant made while ldr_req is high.
- When both requesters are high and streak==MAX_CPU_BURST, the loader wins.
- Streak clears to 0 on any loader grant, and on any CPU grant made while ldr_req is low.
- Only one requester is granted at a time; the other's done stays 0.

Data and strobes:
- rdata registers hold their value until the next read completes for that port. Writes never change rdata.
- mem_addr and mem_wdata hold the last latched values outside ACCESS; strobes are 0 outside ACCESS.
- Widths are passed through unmodified; there is no address arithmetic.

Test Plan:
- Params WAIT_CYCLES=2, MAX_CPU_BURST=4. CPU read of 0x0000_0040 with mem_rdata=0x2402_0005: mem_rd high for cycles 1-2 with mem_addr=0x40, cpu_done at cycle 3, cpu_rdata=0x2402_0005, cpu_stall high in cycles 0-2.
- Loader write of 0x0000_0100 with data 0xDEAD_BEEF: mem_wr high for 2 cycles with mem_wdata=0xDEADBEEF, ldr_done pulse, ldr_rdata remains 0.
- cpu_req and ldr_req high together from idle: CPU is granted first. Loader held high while CPU re-requests continuously: grants go CPU×4, then loader, then CPU again.
- cpu_req drops in cycle 1 of ACCESS: mem_rd is still held for 2 cycles and cpu_done still pulses once.
- nrst pulsed low during ACCESS: mem_rd and mem_wr drop asynchronously, no done pulse, busy=0. After release, a fresh request is serviced normally.
- Back-to-back CPU requests with req held after done: one grant every 4 cycles, each with a single-cycle done pulse.
